// File: rtl/ysyx_25020037_rd_arbiter.sv
// Two-master AXI4-Lite read arbiter: IFU and LSU share one memory read port, one transaction at a time.
// Zero-latency forwarding once granted; grant is registered (request in IDLE -> mem_arvalid next cycle).
module ysyx_25020037_rd_arbiter #(
   parameter bit RR_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,

   input  logic [31:0] ifu_araddr_i,
   input  logic        ifu_arvalid_i,
   output logic        ifu_arready_o,
   output logic [31:0] ifu_rdata_o,
   output logic [1:0]  ifu_rresp_o,
   output logic        ifu_rvalid_o,
   input  logic        ifu_rready_i,

   input  logic [31:0] lsu_araddr_i,
   input  logic        lsu_arvalid_i,
   output logic        lsu_arready_o,
   output logic [31:0] lsu_rdata_o,
   output logic [1:0]  lsu_rresp_o,
   output logic        lsu_rvalid_o,
   input  logic        lsu_rready_i,

   output logic [31:0] mem_araddr_o,
   output logic        mem_arvalid_o,
   input  logic        mem_arready_i,
   input  logic [31:0] mem_rdata_i,
   input  logic [1:0]  mem_rresp_i,
   input  logic        mem_rvalid_i,
   output logic        mem_rready_o
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      AR_IFU = 3'd1,
      R_IFU  = 3'd2,
      AR_LSU = 3'd3,
      R_LSU  = 3'd4
   } state_e;

   localparam logic GRANT_IFU = 1'b0;
   localparam logic GRANT_LSU = 1'b1;

   state_e state_q, state_d;
   logic   last_grant_q, last_grant_d;

   // last_grant resets to LSU so the IFU wins the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= GRANT_LSU;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      mem_araddr_o  = '0;
      mem_arvalid_o = 1'b0;
      mem_rready_o  = 1'b0;
      ifu_arready_o = 1'b0;
      ifu_rvalid_o  = 1'b0;
      ifu_rdata_o   = '0;
      ifu_rresp_o   = '0;
      lsu_arready_o = 1'b0;
      lsu_rvalid_o  = 1'b0;
      lsu_rdata_o   = '0;
      lsu_rresp_o   = '0;

      unique case (state_q)
         IDLE: begin
            if (ifu_arvalid_i && lsu_arvalid_i) begin
               // Tie: round-robin favours whoever was not served last; fixed mode favours LSU.
               if (RR_EN && (last_grant_q == GRANT_LSU)) state_d = AR_IFU;
               else                                      state_d = AR_LSU;
            end else if (ifu_arvalid_i) begin
               state_d = AR_IFU;
            end else if (lsu_arvalid_i) begin
               state_d = AR_LSU;
            end
         end

         AR_IFU: begin
            mem_araddr_o  = ifu_araddr_i;
            mem_arvalid_o = ifu_arvalid_i;
            ifu_arready_o = mem_arready_i;
            if (!ifu_arvalid_i)     state_d = IDLE;
            else if (mem_arready_i) state_d = R_IFU;
         end

         R_IFU: begin
            mem_rready_o = ifu_rready_i;
            ifu_rvalid_o = mem_rvalid_i;
            ifu_rdata_o  = mem_rdata_i;
            ifu_rresp_o  = mem_rresp_i;
            if (mem_rvalid_i && ifu_rready_i) begin
               state_d      = IDLE;
               last_grant_d = GRANT_IFU;
            end
         end

         AR_LSU: begin
            mem_araddr_o  = lsu_araddr_i;
            mem_arvalid_o = lsu_arvalid_i;
            lsu_arready_o = mem_arready_i;
            if (!lsu_arvalid_i)     state_d = IDLE;
            else if (mem_arready_i) state_d = R_LSU;
         end

         R_LSU: begin
            mem_rready_o = lsu_rready_i;
            lsu_rvalid_o = mem_rvalid_i;
            lsu_rdata_o  = mem_rdata_i;
            lsu_rresp_o  = mem_rresp_i;
            if (mem_rvalid_i && lsu_rready_i) begin
               state_d      = IDLE;
               last_grant_d = GRANT_LSU;
            end
         end

         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_ysyx_25020037_rd_arbiter.sv
// Directed vector bench for the read arbiter; one round-robin instance and one fixed-priority instance.
module tb_ysyx_25020037_rd_arbiter;

   typedef struct packed {
      logic        ifu_v;
      logic [31:0] ifu_a;
      logic        ifu_rr;
      logic        lsu_v;
      logic [31:0] lsu_a;
      logic        lsu_rr;
      logic        m_arr;
      logic        m_rv;
      logic [31:0] m_rd;
      logic [1:0]  m_rs;
   } in_t;

   typedef struct packed {
      logic        m_arv;
      logic [31:0] m_ara;
      logic        m_rr;
      logic        i_arr;
      logic        i_rv;
      logic [31:0] i_rd;
      logic [1:0]  i_rs;
      logic        l_arr;
      logic        l_rv;
      logic [31:0] l_rd;
      logic [1:0]  l_rs;
   } out_t;

   typedef struct {
      bit   rst_first;
      bit   fp;
      in_t  i;
      out_t o;
   } vec_t;

   logic        clk, rst;
   logic [31:0] ifu_araddr, lsu_araddr, mem_rdata;
   logic        ifu_arvalid, ifu_rready, lsu_arvalid, lsu_rready;
   logic        mem_arready, mem_rvalid;
   logic [1:0]  mem_rresp;

   logic [31:0] a_ifu_rdata, a_lsu_rdata, a_mem_araddr;
   logic [1:0]  a_ifu_rresp, a_lsu_rresp;
   logic        a_ifu_arready, a_ifu_rvalid, a_lsu_arready, a_lsu_rvalid, a_mem_arvalid, a_mem_rready;
   logic [31:0] b_ifu_rdata, b_lsu_rdata, b_mem_araddr;
   logic [1:0]  b_ifu_rresp, b_lsu_rresp;
   logic        b_ifu_arready, b_ifu_rvalid, b_lsu_arready, b_lsu_rvalid, b_mem_arvalid, b_mem_rready;

   ysyx_25020037_rd_arbiter #(.RR_EN(1'b1)) dut_rr (
      .clk(clk), .rst(rst),
      .ifu_araddr_i(ifu_araddr), .ifu_arvalid_i(ifu_arvalid), .ifu_arready_o(a_ifu_arready),
      .ifu_rdata_o(a_ifu_rdata), .ifu_rresp_o(a_ifu_rresp), .ifu_rvalid_o(a_ifu_rvalid), .ifu_rready_i(ifu_rready),
      .lsu_araddr_i(lsu_araddr), .lsu_arvalid_i(lsu_arvalid), .lsu_arready_o(a_lsu_arready),
      .lsu_rdata_o(a_lsu_rdata), .lsu_rresp_o(a_lsu_rresp), .lsu_rvalid_o(a_lsu_rvalid), .lsu_rready_i(lsu_rready),
      .mem_araddr_o(a_mem_araddr), .mem_arvalid_o(a_mem_arvalid), .mem_arready_i(mem_arready),
      .mem_rdata_i(mem_rdata), .mem_rresp_i(mem_rresp), .mem_rvalid_i(mem_rvalid), .mem_rready_o(a_mem_rready)
   );

   ysyx_25020037_rd_arbiter #(.RR_EN(1'b0)) dut_fp (
      .clk(clk), .rst(rst),
      .ifu_araddr_i(ifu_araddr), .ifu_arvalid_i(ifu_arvalid), .ifu_arready_o(b_ifu_arready),
      .ifu_rdata_o(b_ifu_rdata), .ifu_rresp_o(b_ifu_rresp), .ifu_rvalid_o(b_ifu_rvalid), .ifu_rready_i(ifu_rready),
      .lsu_araddr_i(lsu_araddr), .lsu_arvalid_i(lsu_arvalid), .lsu_arready_o(b_lsu_arready),
      .lsu_rdata_o(b_lsu_rdata), .lsu_rresp_o(b_lsu_rresp), .lsu_rvalid_o(b_lsu_rvalid), .lsu_rready_i(lsu_rready),
      .mem_araddr_o(b_mem_araddr), .mem_arvalid_o(b_mem_arvalid), .mem_arready_i(mem_arready),
      .mem_rdata_i(mem_rdata), .mem_rresp_i(mem_rresp), .mem_rvalid_i(mem_rvalid), .mem_rready_o(b_mem_rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_vec = 0;
   int   n_err = 0;
   vec_t vecs[$];

   function automatic in_t mi(logic iv, logic [31:0] ia, logic irr, logic lv, logic [31:0] la, logic lrr,
                              logic arr, logic rv, logic [31:0] rd, logic [1:0] rs);
      in_t i;
      i.ifu_v = iv;  i.ifu_a = ia;  i.ifu_rr = irr;
      i.lsu_v = lv;  i.lsu_a = la;  i.lsu_rr = lrr;
      i.m_arr = arr; i.m_rv = rv;   i.m_rd = rd;   i.m_rs = rs;
      return i;
   endfunction

   function automatic out_t o_zero();
      out_t o;
      o = '0;
      return o;
   endfunction

   // Address phase toward memory for the given master (lsu=1 selects LSU).
   function automatic out_t o_ar(bit lsu, logic arv, logic [31:0] a, logic arr);
      out_t o;
      o = '0;
      o.m_arv = arv;
      o.m_ara = a;
      if (lsu) o.l_arr = arr;
      else     o.i_arr = arr;
      return o;
   endfunction

   // Data phase from memory to the given master.
   function automatic out_t o_r(bit lsu, logic rr, logic rv, logic [31:0] d, logic [1:0] s);
      out_t o;
      o = '0;
      o.m_rr = rr;
      if (lsu) begin o.l_rv = rv; o.l_rd = d; o.l_rs = s; end
      else     begin o.i_rv = rv; o.i_rd = d; o.i_rs = s; end
      return o;
   endfunction

   function automatic out_t cur(bit fp);
      out_t o;
      if (fp) o = {b_mem_arvalid, b_mem_araddr, b_mem_rready, b_ifu_arready, b_ifu_rvalid, b_ifu_rdata, b_ifu_rresp,
                   b_lsu_arready, b_lsu_rvalid, b_lsu_rdata, b_lsu_rresp};
      else    o = {a_mem_arvalid, a_mem_araddr, a_mem_rready, a_ifu_arready, a_ifu_rvalid, a_ifu_rdata, a_ifu_rresp,
                   a_lsu_arready, a_lsu_rvalid, a_lsu_rdata, a_lsu_rresp};
      return o;
   endfunction

   task automatic add(bit r, bit fp, in_t i, out_t o);
      vec_t v;
      v.rst_first = r; v.fp = fp; v.i = i; v.o = o;
      vecs.push_back(v);
   endtask

   task automatic drive(in_t i);
      ifu_arvalid = i.ifu_v; ifu_araddr = i.ifu_a; ifu_rready = i.ifu_rr;
      lsu_arvalid = i.lsu_v; lsu_araddr = i.lsu_a; lsu_rready = i.lsu_rr;
      mem_arready = i.m_arr; mem_rvalid = i.m_rv;  mem_rdata = i.m_rd;   mem_rresp = i.m_rs;
   endtask

   task automatic check(string name, bit fp, out_t exp);
      out_t got;
      got = cur(fp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s (%s): got %h expected %h", name, fp ? "fixed" : "rr", got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      drive('0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      drive('0);

      // IFU-only read with stray mem_rvalid in IDLE, then an AR whose arvalid drops.
      add(1, 0, mi(1, 32'h8000_0000, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF, 2'b11), o_zero());
      add(0, 0, mi(1, 32'h8000_0000, 0, 0, 0, 0, 1, 0, 0, 0), o_ar(0, 1, 32'h8000_0000, 1));
      add(0, 0, mi(0, 0, 1, 0, 0, 0, 0, 0, 0, 0), o_r(0, 1, 0, 0, 0));
      add(0, 0, mi(0, 0, 1, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0), o_r(0, 1, 1, 32'hDEAD_BEEF, 0));
      add(0, 0, mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), o_zero());
      add(0, 0, mi(1, 32'h7000, 0, 0, 0, 0, 0, 0, 0, 0), o_zero());
      add(0, 0, mi(0, 32'h7000, 0, 0, 0, 0, 1, 0, 0, 0), o_ar(0, 0, 32'h7000, 1));
      add(0, 0, mi(0, 0, 0, 0, 0, 0, 1, 1, 32'h1234, 0), o_zero());

      // Simultaneous requests with round-robin: IFU, LSU, then IFU again.
      add(1, 0, mi(1, 32'h1000, 0, 1, 32'h2000, 0, 0, 0, 0, 0), o_zero());
      add(0, 0, mi(1, 32'h1000, 0, 1, 32'h2000, 0, 1, 0, 0, 0), o_ar(0, 1, 32'h1000, 1));
      add(0, 0, mi(0, 0, 1, 1, 32'h2000, 0, 0, 1, 32'h1111_1111, 0), o_r(0, 1, 1, 32'h1111_1111, 0));
      add(0, 0, mi(0, 0, 0, 1, 32'h2000, 0, 0, 0, 0, 0), o_zero());
      add(0, 0, mi(0, 0, 0, 1, 32'h2000, 0, 1, 0, 0, 0), o_ar(1, 1, 32'h2000, 1));
      add(0, 0, mi(0, 0, 0, 0, 0, 1, 0, 1, 32'h2222_2222, 0), o_r(1, 1, 1, 32'h2222_2222, 0));
      add(0, 0, mi(1, 32'h1004, 0, 1, 32'h2004, 0, 0, 0, 0, 0), o_zero());
      add(0, 0, mi(1, 32'h1004, 0, 1, 32'h2004, 0, 1, 0, 0, 0), o_ar(0, 1, 32'h1004, 1));
      add(0, 0, mi(0, 0, 1, 1, 32'h2004, 0, 0, 1, 32'h3333_3333, 0), o_r(0, 1, 1, 32'h3333_3333, 0));
      add(0, 0, mi(0, 0, 0, 1, 32'h2004, 0, 0, 0, 0, 0), o_zero());
      add(0, 0, mi(0, 0, 0, 1, 32'h2004, 0, 1, 0, 0, 0), o_ar(1, 1, 32'h2004, 1));

      // LSU read: AR wait state, SLVERR held five cycles against rready=0.
      add(1, 0, mi(0, 0, 0, 1, 32'h3000, 0, 0, 0, 0, 0), o_zero());
      add(0, 0, mi(0, 0, 0, 1, 32'h3000, 0, 0, 0, 0, 0), o_ar(1, 1, 32'h3000, 0));
      add(0, 0, mi(0, 0, 0, 1, 32'h3000, 0, 1, 0, 0, 0), o_ar(1, 1, 32'h3000, 1));
      for (int k = 0; k < 5; k++)
         add(0, 0, mi(0, 0, 0, 0, 0, 0, 0, 1, 32'hBAD0_BAD0, 2'b10), o_r(1, 0, 1, 32'hBAD0_BAD0, 2'b10));
      add(0, 0, mi(0, 0, 0, 0, 0, 1, 0, 1, 32'hBAD0_BAD0, 2'b10), o_r(1, 1, 1, 32'hBAD0_BAD0, 2'b10));
      add(0, 0, mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), o_zero());

      // Fixed priority: both requesting for four transactions, LSU wins every time.
      for (int k = 0; k < 4; k++) begin
         add(k == 0, 1, mi(1, 32'h9000, 0, 1, 32'h4000 + 4*k, 0, 0, 0, 0, 0), o_zero());
         add(0, 1, mi(1, 32'h9000, 0, 1, 32'h4000 + 4*k, 0, 1, 0, 0, 0), o_ar(1, 1, 32'h4000 + 4*k, 1));
         add(0, 1, mi(1, 32'h9000, 0, 1, 32'h4000 + 4*k, 1, 0, 1, 32'hA0 + k, 0), o_r(1, 1, 1, 32'hA0 + k, 0));
      end

      foreach (vecs[k]) begin
         if (vecs[k].rst_first) do_reset();
         @(negedge clk);
         drive(vecs[k].i);
         #1;
         check($sformatf("vec%0d", k), vecs[k].fp, vecs[k].o);
      end

      // Reset asserted in R_IFU with a response pending, then a normal re-arbitration.
      do_reset();
      @(negedge clk); drive(mi(1, 32'h5000, 0, 0, 0, 0, 0, 0, 0, 0)); #1;
      check("mid_idle", 0, o_zero());
      @(negedge clk); drive(mi(1, 32'h5000, 0, 0, 0, 0, 1, 0, 0, 0)); #1;
      check("mid_ar", 0, o_ar(0, 1, 32'h5000, 1));
      @(negedge clk); drive(mi(0, 0, 0, 0, 0, 0, 0, 1, 32'h5555_AAAA, 2'b01)); #1;
      check("mid_pending", 0, o_r(0, 0, 1, 32'h5555_AAAA, 2'b01));
      #1 rst = 1'b1;
      #1;
      check("async_rst_rr", 0, o_zero());
      check("async_rst_fp", 1, o_zero());
      @(negedge clk); rst = 1'b0;
      drive(mi(1, 32'h6000, 1, 0, 0, 0, 0, 1, 32'h5555_AAAA, 2'b01)); #1;
      check("post_rst_idle", 0, o_zero());
      @(negedge clk); drive(mi(1, 32'h6000, 1, 0, 0, 0, 1, 1, 32'h5555_AAAA, 2'b01)); #1;
      check("post_rst_ar", 0, o_ar(0, 1, 32'h6000, 1));
      @(negedge clk); drive(mi(0, 0, 1, 0, 0, 0, 0, 1, 32'h6666_0000, 0)); #1;
      check("post_rst_r", 0, o_r(0, 1, 1, 32'h6666_0000, 0));
      @(negedge clk); drive('0); #1;
      check("post_rst_done", 0, o_zero());

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ysyx_25020037_rd_arbiter.md
# ysyx_25020037_rd_arbiter

Two-master AXI4-Lite read-channel arbiter sharing the single memory read port between the IFU (instruction fetch / icache refill) and the LSU (data loads). It grants one complete read transaction (AR handshake through R handshake) at a time. Arbitration is round-robin, or optionally fixed LSU priority. It sits between the core's IFU/LSU read channels and the memory-side AXI read interface; write channels bypass this block.

## Interface
- RR_EN, 1, 1 = round-robin between IFU and LSU; 0 = fixed priority, LSU wins ties
- Reset rst is asynchronous, active-high; clock is clk.
- clk  input  1  clock, all state updates on posedge
- rst  input  1  asynchronous active-high reset
- ifu_araddr  input  32  IFU read address
- ifu_arvalid  input  1  IFU address valid
- ifu_arready  output  1  address accepted for IFU
- ifu_rdata  output  32  read data to IFU
- ifu_rresp  output  2  read response to IFU
- ifu_rvalid  output  1  read data valid to IFU
- ifu_rready  input  1  IFU ready for data
- lsu_araddr, lsu_arvalid, lsu_arready, lsu_rdata, lsu_rresp, lsu_rvalid, lsu_rready  same directions/widths as the IFU ports, LSU side
- mem_araddr  output  32  address to memory
- mem_arvalid  output  1  address valid to memory
- mem_arready  input  1  memory accepts address
- mem_rdata  input  32  memory read data
- mem_rresp  input  2  memory read response
- mem_rvalid  input  1  memory data valid
- mem_rready  output  1  ready for memory data

## Operation
- States: IDLE, AR_IFU, R_IFU, AR_LSU, R_LSU. Registered: state, last_grant (0 = IFU, 1 = LSU).
- IDLE: only ifu_arvalid -> AR_IFU; only lsu_arvalid -> AR_LSU; both: with RR_EN=1, grant the master not equal to last_grant; with RR_EN=0, grant LSU. Neither -> stay.
- AR_x: mem_araddr/mem_arvalid = granted master's araddr/arvalid; x_arready = mem_arready. Handshake (mem_arvalid && mem_arready) -> R_x. If granted arvalid drops before the handshake (protocol violation), -> IDLE with no transfer.
- R_x: mem_rready = x_rready; x_rvalid = mem_rvalid; x_rdata/x_rresp = mem_rdata/mem_rresp. Handshake (mem_rvalid && mem_rready) -> IDLE, last_grant <= x.
- rresp is forwarded unmodified, including SLVERR/DECERR. The arbiter never generates responses.
- The non-granted master always sees arready=0, rvalid=0, rdata=0, rresp=0.
- mem_rvalid seen in IDLE or AR_x is ignored (mem_rready=0). mem_arvalid=0 in IDLE and R_x.
- One outstanding transaction total. The IFU multi-beat refill is a sequence of single transactions, and the LSU may interleave between beats.

## Timing
- All outputs are combinational from state plus the granted master's and memory's signals. There are no registered datapaths.
- Reset (any cycle, including mid-transaction): state=IDLE, last_grant=1 (so IFU wins the first tie). All outputs are 0: mem_arvalid, mem_rready, mem_araddr, *_arready, *_rvalid, *_rdata, *_rresp. An in-flight memory response is abandoned.
- Arbitration latency: a request visible in IDLE at cycle t gives mem_arvalid=1 at t+1.
- Minimum transaction: IDLE -> AR (arready same cycle) -> R (rvalid same cycle) -> IDLE = 3 cycles. Back-to-back grants to alternating masters run at that rate.
- Requests arriving during AR/R wait; the requester's arvalid must stay held (AXI rule). The arbiter never drops a held request.
- Starvation bound with RR_EN=1: a waiting master is granted after at most one transaction of the other master.

## Test plan
- Reset, then IFU-only read of 0x8000_0000, with memory arready at t+1 and rvalid with 0xDEADBEEF/OKAY two cycles later -> ifu_rdata=0xDEADBEEF, ifu_rresp=0, LSU outputs stay 0, state back to IDLE.
- IFU and LSU assert arvalid in the same cycle right after reset, RR_EN=1 -> IFU served first, then LSU. Repeat the simultaneous request -> IFU again, since last_grant=LSU.
- RR_EN=0, both requesting continuously for 4 transactions -> all 4 grants go to LSU and IFU arready stays 0.
- Memory returns rresp=2'b10 on an LSU read -> lsu_rresp=2'b10 passed through and the arbiter returns to IDLE normally.
- LSU holds rready=0 for 5 cycles while mem_rvalid=1 -> mem_rready=0 for those cycles, data stays pending, and the handshake completes on the cycle rready rises.
- Assert rst in R_IFU with mem_rvalid pending -> all outputs 0 immediately (async), state IDLE, and the next IFU request is re-arbitrated normally.
